// File: rtl/fc_l2_data_arbiter.sv
// Two-port arbiter sharing the FC L2 data master (TCDM req/gnt/r_valid), with an in-order owner FIFO for response routing.
// Define FC_L2_ARB_RR_EN for round-robin priority; default build is fixed priority (port 0 first).
module fc_l2_data_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s0_req_i,
  input  logic [ADDR_WIDTH-1:0]          s0_add_i,
  input  logic                           s0_wen_i,
  input  logic [DATA_WIDTH-1:0]          s0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        s0_be_i,
  output logic                           s0_gnt_o,
  output logic                           s0_r_valid_o,
  output logic [DATA_WIDTH-1:0]          s0_r_rdata_o,
  output logic                           s0_r_opc_o,
  input  logic                           s1_req_i,
  input  logic [ADDR_WIDTH-1:0]          s1_add_i,
  input  logic                           s1_wen_i,
  input  logic [DATA_WIDTH-1:0]          s1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        s1_be_i,
  output logic                           s1_gnt_o,
  output logic                           s1_r_valid_o,
  output logic [DATA_WIDTH-1:0]          s1_r_rdata_o,
  output logic                           s1_r_opc_o,
  output logic                           m_req_o,
  output logic [ADDR_WIDTH-1:0]          m_add_o,
  output logic                           m_wen_o,
  output logic [DATA_WIDTH-1:0]          m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        m_be_o,
  input  logic                           m_gnt_i,
  input  logic                           m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          m_r_rdata_i,
  input  logic                           m_r_opc_i,
  output logic [$clog2(MAX_OUTST):0]     outstanding_o,
  output logic                           proto_err_o
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   add;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
  } req_t;

  typedef enum logic {S_IDLE, S_WAIT} lock_state_t;

  req_t [1:0]  port_req;
  req_t        fwd;
  logic [1:0]  req;
  logic        pick, sel, lock_port, gnt;
  logic        full, empty, push, pop, head;
  lock_state_t state, state_nxt;

  logic [MAX_OUTST-1:0] owner_q;
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;

  assign req         = {s1_req_i, s0_req_i};
  assign port_req[0] = '{add: s0_add_i, wen: s0_wen_i, wdata: s0_wdata_i, be: s0_be_i};
  assign port_req[1] = '{add: s1_add_i, wen: s1_wen_i, wdata: s1_wdata_i, be: s1_be_i};

`ifdef FC_L2_ARB_RR_EN
  // prio names the port favoured next; it flips to the other port after each grant
  logic prio;

  always_ff @(posedge clk_i) begin
    if (rst_i)    prio <= 1'b0;
    else if (gnt) prio <= ~sel;
  end

  always_comb begin
    pick = prio;
    if (!req[prio] && req[~prio]) pick = ~prio;
  end
`else
  always_comb pick = !req[0] && req[1];
`endif

  // an ungranted request keeps the master port until it is accepted
  assign sel     = (state == S_WAIT) ? lock_port : pick;
  assign full    = (count == CW'(MAX_OUTST));
  assign empty   = (count == '0);
  assign m_req_o = req[sel] && !full;
  assign gnt     = m_req_o && m_gnt_i;
  assign fwd     = m_req_o ? port_req[sel] : '0;

  assign m_add_o   = fwd.add;
  assign m_wen_o   = fwd.wen;
  assign m_wdata_o = fwd.wdata;
  assign m_be_o    = fwd.be;

  assign s0_gnt_o = gnt && !sel;
  assign s1_gnt_o = gnt && sel;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (m_req_o && !m_gnt_i) state_nxt = S_WAIT;
      S_WAIT:  if (gnt)                 state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      lock_port <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_WAIT) lock_port <= sel;
    end
  end

  assign push = gnt;
  assign pop  = m_r_valid_i && !empty;
  assign head = owner_q[rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q     <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wptr] <= sel;
        wptr          <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (m_r_valid_i && empty) proto_err_o <= 1'b1;
    end
  end

  assign outstanding_o = count;

  // response data is shared; only the recorded owner sees r_valid
  assign s0_r_valid_o = pop && !head;
  assign s1_r_valid_o = pop && head;
  assign s0_r_rdata_o = pop ? m_r_rdata_i : '0;
  assign s1_r_rdata_o = pop ? m_r_rdata_i : '0;
  assign s0_r_opc_o   = pop && m_r_opc_i;
  assign s1_r_opc_o   = pop && m_r_opc_i;

endmodule
